// File: rtl/ram_writer_if.sv
// Valid/ready word stream feeding ram_writer.
`timescale 1ns/1ps
interface ram_writer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] din;
    logic                         din_valid;
    logic                         din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/ram_writer.sv
// Loads a burst from a valid/ready stream into a dual-port RAM at a wrapping base address;
// independent registered read port. Optional burst checksum under RAM_WRITER_CHECKSUM_EN.
`timescale 1ns/1ps
module ram_writer #(
    parameter int unsigned ADDRESS_WIDTH = 7,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned RAM_SIZE      = 128
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [ADDRESS_WIDTH-1:0]        i_base_addr,
    input  logic [ADDRESS_WIDTH:0]          i_length,
    ram_writer_if.slave                     s_if,
    output logic                            o_busy,
    output logic                            o_done,
    input  logic                            i_en2,
    input  logic [ADDRESS_WIDTH-1:0]        i_addr2,
    output logic signed [DATA_WIDTH-1:0]    o_do2,
    output logic [DATA_WIDTH-1:0]           o_checksum
);
    localparam int unsigned LW = ADDRESS_WIDTH + 1;
    localparam logic [LW-1:0] SIZE_L = LW'(RAM_SIZE);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]     r_wa;
    logic [LW-1:0]                r_len;
    logic [LW-1:0]                r_count;
    logic                         r_din_ready;
    logic                         r_busy;
    logic                         r_done;
    logic signed [DATA_WIDTH-1:0] r_do2;
    logic                         w_start_acc;
    logic                         w_hs;
    logic                         w_we;
    logic                         w_last;
    logic [ADDRESS_WIDTH-1:0]     w_base_wrapped;

    logic signed [DATA_WIDTH-1:0] r_mem [RAM_SIZE];

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_hs        = s_if.din_valid && r_din_ready;
    assign w_we        = w_hs && !rst;
    assign w_last      = (r_count == r_len - LW'(1));
    // Base may exceed RAM_SIZE when RAM_SIZE is not a power of two.
    assign w_base_wrapped = ({1'b0, i_base_addr} >= SIZE_L)
                          ? ADDRESS_WIDTH'({1'b0, i_base_addr} - SIZE_L)
                          : i_base_addr;

    assign s_if.din_ready = r_din_ready;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_do2          = r_do2;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_length != '0) ? S_LOAD : S_FINISH;
                end
            end
            S_LOAD: begin
                if (w_hs && w_last) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_din_ready <= (w_state_nxt == S_LOAD);
            r_busy      <= (w_state_nxt == S_LOAD);
            r_done      <= (w_state_nxt == S_FINISH);
        end
    end

    // Burst bookkeeping: wrapping write address and word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wa    <= '0;
            r_len   <= '0;
            r_count <= '0;
        end else if (w_start_acc) begin
            r_wa    <= w_base_wrapped;
            r_len   <= i_length;
            r_count <= '0;
        end else if (w_hs) begin
            r_count <= r_count + LW'(1);
            r_wa    <= (r_wa == LAST_ADDR) ? '0 : r_wa + ADDRESS_WIDTH'(1);
        end
    end

    // Write port.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wa] <= s_if.din;
        end
    end

    // Read port, read-first against a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_do2 <= '0;
        end else if (i_en2) begin
            r_do2 <= r_mem[i_addr2];
        end
    end

`ifdef RAM_WRITER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic [DATA_WIDTH-1:0] r_checksum;

    always_comb begin
        w_acc_nxt = r_acc;
        if (w_start_acc) begin
            w_acc_nxt = '0;
        end else if (w_hs) begin
            w_acc_nxt = r_acc + $unsigned(s_if.din);
        end
    end

    // Checksum publishes in the done cycle and holds until the next burst completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_checksum <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            if (w_state_nxt == S_FINISH && r_state != S_FINISH) begin
                r_checksum <= w_acc_nxt;
            end
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_ram_writer.sv
// Directed self-checking bench for ram_writer; checksum expectations follow RAM_WRITER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_ram_writer;
    logic        clk;
    logic        rst;
    logic        i_start;
    logic [6:0]  i_base_addr;
    logic [7:0]  i_length;
    logic        o_busy;
    logic        o_done;
    logic        i_en2;
    logic [6:0]  i_addr2;
    logic signed [15:0] o_do2;
    logic [15:0] o_checksum;

    ram_writer_if #(.DATA_WIDTH(16)) s_if ();

    ram_writer #(.ADDRESS_WIDTH(7), .DATA_WIDTH(16), .RAM_SIZE(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_length    (i_length),
        .s_if        (s_if),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .i_en2       (i_en2),
        .i_addr2     (i_addr2),
        .o_do2       (o_do2),
        .o_checksum  (o_checksum)
    );

`ifdef RAM_WRITER_CHECKSUM_EN
    localparam logic [15:0] CK_BASIC = 16'h00AA;
    localparam logic [15:0] CK_SUM3  = 16'h0011;
`else
    localparam logic [15:0] CK_BASIC = 16'h0000;
    localparam logic [15:0] CK_SUM3  = 16'h0000;
`endif

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t     rtab [18];
    logic [15:0] tx [8];
    int          n_vec;
    int          n_err;
    int          dones;
    logic [15:0] cks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_read(input string nm, input logic [6:0] a, input logic [15:0] exp);
        i_en2   = 1'b1;
        i_addr2 = a;
        tick();
        i_en2 = 1'b0;
        chk(nm, o_do2, exp);
    endtask

    // Start a burst from tx[], optionally toggling din_valid, and count done pulses.
    task automatic burst(input logic [6:0] b, input logic [7:0] n, input bit tog);
        int idx;
        int cyc;
        bit hs;
        dones = 0;
        i_start = 1'b1; i_base_addr = b; i_length = n;
        tick();
        i_start = 1'b0;
        if (o_done) begin dones++; cks = o_checksum; end
        idx = 0;
        cyc = 0;
        while (idx < int'(n) && cyc < 100) begin
            s_if.din       = tx[idx[2:0]];
            s_if.din_valid = tog ? (cyc % 2 == 0) : 1'b1;
            hs = s_if.din_valid && s_if.din_ready;
            tick();
            if (hs) idx++;
            if (o_done) begin dones++; cks = o_checksum; end
            cyc++;
        end
        s_if.din_valid = 1'b0;
        chk("burst_budget", 16'(cyc >= 100), 16'h0);
        repeat (3) begin
            tick();
            if (o_done) dones++;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; dones = 0; cks = '0;
        rtab[0]  = '{7'd0,   16'hA003}; rtab[1]  = '{7'd1,   16'hA004};
        rtab[2]  = '{7'd2,   16'h0033}; rtab[3]  = '{7'd3,   16'h0044};
        rtab[4]  = '{7'd126, 16'hA001}; rtab[5]  = '{7'd127, 16'hA002};
        rtab[6]  = '{7'd10,  16'hB001}; rtab[7]  = '{7'd11,  16'hB002};
        rtab[8]  = '{7'd12,  16'hB003}; rtab[9]  = '{7'd13,  16'hB004};
        rtab[10] = '{7'd5,   16'hABCD}; rtab[11] = '{7'd20,  16'hD000};
        rtab[12] = '{7'd21,  16'hD001}; rtab[13] = '{7'd22,  16'hD002};
        rtab[14] = '{7'd23,  16'hC003}; rtab[15] = '{7'd40,  16'hFFFF};
        rtab[16] = '{7'd41,  16'h0002}; rtab[17] = '{7'd42,  16'h0010};

        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_length = '0;
        i_en2 = 1'b0; i_addr2 = '0; s_if.din = '0; s_if.din_valid = 1'b0;
        tick(); tick();
        chk("rst_busy", 16'(o_busy), 16'h0);
        chk("rst_done", 16'(o_done), 16'h0);
        chk("rst_ready", 16'(s_if.din_ready), 16'h0);
        chk("rst_do2", o_do2, 16'h0);
        chk("rst_checksum", o_checksum, 16'h0);
        rst = 1'b0;
        // din_valid outside LOAD must not write
        s_if.din = 16'h7777; s_if.din_valid = 1'b1;
        tick();
        s_if.din_valid = 1'b0;
        chk("idle_ready", 16'(s_if.din_ready), 16'h0);

        // Basic load
        tx[0] = 16'h0011; tx[1] = 16'h0022; tx[2] = 16'h0033; tx[3] = 16'h0044;
        i_start = 1'b1; i_base_addr = 7'd0; i_length = 8'd4;
        tick();
        i_start = 1'b0;
        chk("basic_busy", 16'(o_busy), 16'h1);
        chk("basic_ready", 16'(s_if.din_ready), 16'h1);
        for (int i = 0; i < 4; i++) begin
            s_if.din = tx[i]; s_if.din_valid = 1'b1;
            tick();
            if (i < 3) chk("basic_done_early", 16'(o_done), 16'h0);
        end
        s_if.din_valid = 1'b0;
        chk("basic_done", 16'(o_done), 16'h1);
        chk("basic_busy_end", 16'(o_busy), 16'h0);
        chk("basic_ready_end", 16'(s_if.din_ready), 16'h0);
        chk("basic_checksum", o_checksum, CK_BASIC);
        tick();
        chk("basic_done_1cyc", 16'(o_done), 16'h0);
        chk("basic_ck_hold", o_checksum, CK_BASIC);
        for (int i = 0; i < 4; i++) do_read("basic_read", 7'(i), tx[i]);

        // Wrap with stalls
        tx[0] = 16'hA001; tx[1] = 16'hA002; tx[2] = 16'hA003; tx[3] = 16'hA004;
        burst(7'd126, 8'd4, 1'b1);
        chk("wrap_dones", 16'(dones), 16'h1);

        // Start while busy and start in the done cycle
        i_start = 1'b1; i_base_addr = 7'd10; i_length = 8'd4;
        tick();
        for (int i = 0; i < 4; i++) begin
            s_if.din = 16'(16'hB001 + i); s_if.din_valid = 1'b1;
            i_start = (i == 2);
            i_base_addr = (i == 2) ? 7'd50 : 7'd10;
            i_length    = (i == 2) ? 8'd2 : 8'd4;
            tick();
        end
        i_start = 1'b0; s_if.din_valid = 1'b0;
        chk("busy_start_done", 16'(o_done), 16'h1);
        i_start = 1'b1; i_base_addr = 7'd60; i_length = 8'd1;
        tick();
        i_start = 1'b0;
        chk("done_start_busy", 16'(o_busy), 16'h0);
        chk("done_start_ready", 16'(s_if.din_ready), 16'h0);
        tick();
        chk("done_start_idle", 16'(o_busy), 16'h0);

        // Read-first collision
        tx[0] = 16'h1234;
        burst(7'd5, 8'd1, 1'b0);
        do_read("pre_collide", 7'd5, 16'h1234);
        i_start = 1'b1; i_base_addr = 7'd5; i_length = 8'd1;
        tick();
        i_start = 1'b0;
        s_if.din = 16'hABCD; s_if.din_valid = 1'b1;
        i_en2 = 1'b1; i_addr2 = 7'd5;
        tick();
        s_if.din_valid = 1'b0;
        chk("collide_old", o_do2, 16'h1234);
        tick();
        i_en2 = 1'b0; i_addr2 = 7'd0;
        chk("collide_new", o_do2, 16'hABCD);
        tick();
        chk("en2_hold", o_do2, 16'hABCD);

        // Reset mid-burst
        tx[0] = 16'hC000; tx[1] = 16'hC001; tx[2] = 16'hC002; tx[3] = 16'hC003;
        burst(7'd20, 8'd4, 1'b0);
        i_start = 1'b1; i_base_addr = 7'd20; i_length = 8'd8;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_if.din = 16'(16'hD000 + i); s_if.din_valid = 1'b1;
            tick();
        end
        s_if.din = 16'hD003; rst = 1'b1;
        tick();
        chk("mid_rst_busy", 16'(o_busy), 16'h0);
        chk("mid_rst_ready", 16'(s_if.din_ready), 16'h0);
        chk("mid_rst_done", 16'(o_done), 16'h0);
        chk("mid_rst_do2", o_do2, 16'h0);
        rst = 1'b0; s_if.din_valid = 1'b0;
        dones = 0;
        repeat (4) begin
            tick();
            if (o_done) dones++;
        end
        chk("mid_rst_no_done", 16'(dones), 16'h0);

        // Checksum burst, then zero-length burst
        tx[0] = 16'hFFFF; tx[1] = 16'h0002; tx[2] = 16'h0010;
        cks = 16'hDEAD;
        burst(7'd40, 8'd3, 1'b0);
        chk("ck_dones", 16'(dones), 16'h1);
        chk("ck_value", cks, CK_SUM3);
        i_start = 1'b1; i_base_addr = 7'd0; i_length = 8'd0;
        tick();
        i_start = 1'b0;
        chk("zero_done", 16'(o_done), 16'h1);
        chk("zero_busy", 16'(o_busy), 16'h0);
        chk("zero_checksum", o_checksum, 16'h0);
        tick();
        chk("zero_done_1cyc", 16'(o_done), 16'h0);

        // Final RAM image
        for (int i = 0; i < 18; i++) begin
            do_read($sformatf("ram[%0d]", rtab[i].addr), rtab[i].addr, rtab[i].exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_writer.md
Name: ram_writer

Overview:
- Fills an on-chip dual-port block RAM with a burst of words from a valid/ready stream. Writes are sequential, starting at a programmable base address.
- Exposes an independent, registered, read-only second port, so downstream logic reads coefficient/sample tables that were loaded at run time rather than from an init file.
- Sits between a host/config stream source and DSP consumers of table data.

Parameters:
- ADDRESS_WIDTH, 7, width of all address ports.
- DATA_WIDTH, 16, width of stored words (signed).
- RAM_SIZE, 128, number of words; must be ≤ 2**ADDRESS_WIDTH.

Ports:
- clk  input  1  single clock for all logic and both RAM ports.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a load burst.
- base_addr  input  ADDRESS_WIDTH  first write address, sampled on start.
- length  input  ADDRESS_WIDTH+1  number of words to write, sampled on start.
- din  input  DATA_WIDTH signed  stream data.
- din_valid  input  1  stream data valid.
- din_ready  output  1  writer accepts din this cycle.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when the burst completes.
- en2  input  1  read port enable.
- addr2  input  ADDRESS_WIDTH  read address.
- do2  output  DATA_WIDTH signed  read data.
- checksum  output  DATA_WIDTH  burst checksum (see Optional Feature).

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: din_ready=0, busy=0, done=0, do2=0, checksum=0, internal count=0, state=IDLE. RAM contents are not cleared by reset.

FSM states and transitions:
- IDLE:
  - On start with length≠0: latch base_addr and length, count=0, go to LOAD.
  - On start with length=0: go to FINISH.
- LOAD:
  - din_ready=1 and busy=1.
  - Handshake fires when din_valid&din_ready.
  - On each handshake: write din to address wa=(base+count) mod RAM_SIZE, then count++.
  - When the handshake has count==length-1: go to FINISH the next cycle; din_ready deasserts that next cycle.
- FINISH:
  - done=1 for exactly one cycle, busy=0, din_ready=0.
  - Return to IDLE.

Write address and timing:
- Write address wraps: base+count ≥ RAM_SIZE subtracts RAM_SIZE. No power-of-two assumption.
- Write latency: data is in RAM at the clock edge of the handshake. It is readable on port 2 from the following cycle, and appears on do2 one cycle after that read.

Boundary and error behaviour:
- start while busy (LOAD or FINISH): ignored. The burst continues unchanged.
- start asserted in the same cycle as done: ignored. A new burst needs start while IDLE.
- length > RAM_SIZE: the address wraps and earlier words in the burst are overwritten. This is legal and not flagged.
- din_valid outside LOAD: no write, no stall effects.
- rst mid-burst: the burst is aborted next edge, with all outputs at reset values. Words already written remain in RAM. done is not pulsed.

Read port:
- When en2=1: do2 <= mem[addr2] at the clock edge, giving 1-cycle latency.
- When en2=0: do2 holds its value.
- addr2 ≥ RAM_SIZE returns undefined data; the bench must not check it.
- Read-during-write to the same address returns the old data (read-first).

Implementation:
- The memory is an inferred array suitable for BRAM mapping.
- The write port and read port are separate always blocks on clk.

Optional Feature:
- Macro: RAM_WRITER_CHECKSUM_EN.
- Defined:
  - A DATA_WIDTH accumulator clears on accepted start.
  - On each handshake it adds din, modulo 2**DATA_WIDTH, treating din as unsigned bits.
  - checksum is updated in the cycle done pulses and holds until the next accepted start or reset.
  - length=0 gives checksum 0.
- Undefined: checksum is tied to 0 and no accumulator logic is generated.
- All other behaviour is identical in both builds.

Test Plan:
- Basic load:
  - Stimulus: rst, then start with base=0, length=4; stream 0x0011,0x0022,0x0033,0x0044 with din_valid held high.
  - Response: done pulses 1 cycle after the 4th handshake, busy is low after.
  - Read back: reading addr2=0..3 gives do2 = the same values, each 1 cycle after en2.
- Wrap and stall:
  - Stimulus: base=126, length=4, RAM_SIZE=128; din_valid toggles 1,0,1,0,...
  - Response: writes land at 126,127,0,1; no write in cycles where din_valid=0; done fires exactly once.
- Zero length and busy start:
  - Stimulus: start with length=0.
  - Response: done pulses the next cycle, no RAM change.
  - Stimulus: start pulsed mid-LOAD with different base.
  - Response: ignored; the original addresses are written.
- Read-first collision:
  - Setup: addr 5 holds 0x1234.
  - Stimulus: a handshake writes 0xABCD to addr 5 in the same cycle as en2=1, addr2=5.
  - Response: do2=0x1234; the next read gives 0xABCD.
- Reset mid-burst:
  - Stimulus: length=8; assert rst after 3 handshakes.
  - Response: busy/din_ready/done go to 0 the next cycle and done never pulses. Addresses base..base+2 hold data; base+3 is unchanged.
- Checksum (RAM_WRITER_CHECKSUM_EN defined):
  - Stimulus: burst 0xFFFF,0x0002,0x0010.
  - Response: checksum=0x0011 when done pulses.
  - Undefined build: checksum stays 0.
